// File: rtl/circuito_exp5.sv
// circuito_exp5: 16-play memory game, ROM sequence compared against one-hot switch plays
module circuito_exp5 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada
);
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;
  localparam logic [3:0] ROM [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d, jog_q, jog_d, codigo, memoria;
  logic       prev_q, tem_q, clr, inc, ld, fim;
  assign memoria = ROM[cnt_q];
  assign fim     = cnt_q == 4'hF;
  assign codigo  = estado_q;
  always_comb begin
    estado_d = estado_q;
    clr = 1'b0;
    inc = 1'b0;
    ld  = 1'b0;
    case (estado_q)
      INICIAL:     estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  begin clr = 1'b1; estado_d = ESPERA; end
      ESPERA:      estado_d = tem_q ? REGISTRA : ESPERA;
      REGISTRA:    begin ld = 1'b1; estado_d = COMPARACAO; end
      COMPARACAO:  estado_d = (jog_q != memoria) ? FIM_ERROU : fim ? FIM_ACERTOU : PROXIMO;
      PROXIMO:     begin inc = 1'b1; estado_d = ESPERA; end
      FIM_ACERTOU: estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:   estado_d = iniciar ? PREPARACAO : FIM_ERROU;
      default:     estado_d = INICIAL;
    endcase
  end
  assign cnt_d = clr ? 4'h0 : inc ? cnt_q + 4'h1 : cnt_q;
  assign jog_d = clr ? 4'h0 : ld ? chaves : jog_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      cnt_q    <= 4'h0;
      jog_q    <= 4'h0;
      prev_q   <= 1'b0;
      tem_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      jog_q    <= jog_d;
      prev_q   <= |chaves;
      tem_q    <= (|chaves) & ~prev_q;
    end
  end
  assign acertou        = estado_q == FIM_ACERTOU;
  assign errou          = estado_q == FIM_ERROU;
  assign pronto         = acertou | errou;
  assign leds           = chaves;
  assign db_igual       = jog_q == memoria;
  assign db_contagem    = SEG[cnt_q];
  assign db_memoria     = SEG[memoria];
  assign db_estado      = SEG[codigo];
  assign db_jogadafeita = SEG[jog_q];
  assign db_clock       = clock;
  assign db_iniciar     = iniciar;
  assign db_tem_jogada  = tem_q;
endmodule

// File: tb/tb_circuito_exp5.sv
// tb_circuito_exp5: vector table, directed game sequences and random games vs a play-level model
module tb_circuito_exp5;
  logic       clock = 1'b0, reset = 1'b1, iniciar = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;
  int passes = 0, total = 0, pulses = 0;
  localparam logic [3:0] ROM [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef struct {
    logic [3:0] ch;
    logic       igual;
    logic [3:0] code_after;
  } vec_t;
  vec_t tbl [5];

  circuito_exp5 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
    .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (db_tem_jogada) pulses++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    repeat (5) tick();
    iniciar = 1'b0;
    tick();
  endtask

  task automatic play(input logic [3:0] v, input int hold, input int idle);
    chaves = v;
    repeat (hold) tick();
    chaves = 4'h0;
    repeat (idle) tick();
  endtask

  task automatic check_end(input string nm, input logic ok, input int k, input logic [3:0] last);
    check({nm, "_acertou"}, {6'd0, acertou}, {6'd0, ok});
    check({nm, "_errou"}, {6'd0, errou}, {6'd0, ~ok});
    check({nm, "_pronto"}, {6'd0, pronto}, 7'd1);
    check({nm, "_estado"}, db_estado, ok ? SEG[10] : SEG[14]);
    check({nm, "_contagem"}, db_contagem, SEG[k]);
    check({nm, "_jogada"}, db_jogadafeita, SEG[last]);
  endtask

  initial begin
    tbl[0] = '{4'h1, 1'b1, 4'h6};
    tbl[1] = '{4'h2, 1'b0, 4'hE};
    tbl[2] = '{4'h3, 1'b0, 4'hE};
    tbl[3] = '{4'hF, 1'b0, 4'hE};
    tbl[4] = '{4'h8, 1'b0, 4'hE};

    do_reset();
    check("rst_acertou", {6'd0, acertou}, 7'd0);
    check("rst_errou", {6'd0, errou}, 7'd0);
    check("rst_pronto", {6'd0, pronto}, 7'd0);
    check("rst_estado", db_estado, SEG[0]);
    check("rst_contagem", db_contagem, SEG[0]);
    check("rst_memoria", db_memoria, SEG[1]);
    check("rst_jogada", db_jogadafeita, SEG[0]);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      start();
      chaves = tbl[i].ch;
      #1;
      check("tbl_leds", {3'd0, leds}, {3'd0, tbl[i].ch});
      repeat (3) tick();
      check("tbl_cmp_estado", db_estado, SEG[5]);
      check("tbl_igual", {6'd0, db_igual}, {6'd0, tbl[i].igual});
      tick();
      check("tbl_after", db_estado, SEG[tbl[i].code_after]);
      chaves = 4'h0;
      repeat (3) tick();
    end

    do_reset();
    start();
    for (int i = 0; i < 16; i++) begin
      pulses = 0;
      play(ROM[i], int'($urandom_range(5, 10)), 10);
      check("full_pulse", 7'(pulses), 7'd1);
    end
    check_end("full", 1'b1, 15, 4'h4);

    do_reset();
    start();
    play(4'h1, 6, 10);
    play(4'h2, 6, 10);
    play(4'h8, 6, 10);
    check_end("err3", 1'b0, 2, 4'h8);
    iniciar = 1'b1;
    tick();
    check("restart_prep", db_estado, SEG[1]);
    check("restart_pronto", {6'd0, pronto}, 7'd0);
    tick();
    iniciar = 1'b0;
    check("restart_espera", db_estado, SEG[2]);
    check("restart_errou", {6'd0, errou}, 7'd0);
    check("restart_contagem", db_contagem, SEG[0]);

    pulses = 0;
    play(4'h1, 10, 10);
    check("hold_pulse", 7'(pulses), 7'd1);
    check("hold_contagem", db_contagem, SEG[1]);

    do_reset();
    start();
    for (int i = 0; i < 5; i++) play(ROM[i], 6, 10);
    check("mid_contagem_pre", db_contagem, SEG[5]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_estado", db_estado, SEG[0]);
    check("mid_rst_contagem", db_contagem, SEG[0]);
    check("mid_rst_pronto", {6'd0, pronto}, 7'd0);
    start();
    check("fresh_contagem", db_contagem, SEG[0]);
    play(4'h1, 6, 10);
    check("fresh_step", db_contagem, SEG[1]);
    check("fresh_estado", db_estado, SEG[2]);

    for (int g = 0; g < 6; g++) begin
      logic [3:0] v;
      int k;
      logic ok;
      if (g == 0 || $urandom_range(0, 1) == 0) do_reset();
      start();
      ok = 1'b1;
      k = 0;
      v = 4'h0;
      for (int i = 0; i < 16; i++) begin
        v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : ROM[i];
        pulses = 0;
        play(v, int'($urandom_range(5, 10)), int'($urandom_range(2, 10)));
        check("rnd_pulse", 7'(pulses), 7'd1);
        k = i;
        if (v != ROM[i]) begin
          ok = 1'b0;
          break;
        end
      end
      check_end("rnd", ok, k, v);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
